// File: rtl/param_systolic_matmul.sv
`default_nettype none
// ============================================================================
// Module      : param_systolic_matmul
// Description : NxN output-stationary systolic matrix multiplier. Reads A
//               columns and B rows from two memories with 1-cycle read
//               latency, skews them into the PE grid, then writes the
//               accumulated C matrix out one row per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module param_systolic_matmul #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 10,
  parameter int OW = 2*DW + $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            accumulate,
  input  logic [7:0]      k_len,
  input  logic [AW-1:0]   addr_a,
  input  logic [AW-1:0]   addr_b,
  input  logic [AW-1:0]   addr_c,
  input  logic [7:0]      stride_a,
  input  logic [7:0]      stride_b,
  input  logic [7:0]      stride_c,
  input  logic [N-1:0]    row_mask,
  input  logic [N-1:0]    col_mask,
  output logic [AW-1:0]   a_rd_addr,
  input  logic [N*DW-1:0] a_rd_data,
  output logic [AW-1:0]   b_rd_addr,
  input  logic [N*DW-1:0] b_rd_data,
  output logic            c_wr_en,
  output logic [AW-1:0]   c_wr_addr,
  output logic [N*OW-1:0] c_wr_data,
  output logic            busy,
  output logic            done,
  input  logic            clear_done
);

  // Counter must hold K-1 (8 bits) and the 2N-cycle drain.
  localparam int CW = ($clog2(2*N) + 1 > 8) ? $clog2(2*N) + 1 : 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      k_len_q, k_len_d;
  logic [AW-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
  logic [7:0]      stride_a_q, stride_a_d, stride_b_q, stride_b_d, stride_c_q, stride_c_d;
  logic [N-1:0]    row_mask_q, row_mask_d, col_mask_q, col_mask_d;
  logic            feed_vld_q, feed_vld_d;
  logic            done_q, done_d;

  logic            accept;
  logic            last_feed, last_drain, last_write;

  logic [DW-1:0]   a_lane [N];
  logic [DW-1:0]   b_lane [N];
  logic [DW-1:0]   a_skew [N];
  logic [DW-1:0]   b_skew [N];
  logic [DW-1:0]   a_out  [N][N];
  logic [DW-1:0]   b_out  [N][N];
  logic [OW-1:0]   acc_w  [N][N];

  assign accept     = (state_q == S_IDLE) && start;
  assign last_feed  = (cnt_q == CW'(k_len_q) - CW'(1));
  // Drain covers the memory read latency plus 2N-1 skew/propagation cycles.
  assign last_drain = (cnt_q == CW'(2*N - 1));
  assign last_write = (cnt_q == CW'(N - 1));

  // Sequencer: config latch, address walkers, phase counter and done flag.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_len_d    = k_len_q;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    c_addr_d   = c_addr_q;
    stride_a_d = stride_a_q;
    stride_b_d = stride_b_q;
    stride_c_d = stride_c_q;
    row_mask_d = row_mask_q;
    col_mask_d = col_mask_q;
    feed_vld_d = (state_q == S_FEED);
    done_d     = done_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_len_d    = k_len;
          a_addr_d   = addr_a;
          b_addr_d   = addr_b;
          c_addr_d   = addr_c;
          stride_a_d = stride_a;
          stride_b_d = stride_b;
          stride_c_d = stride_c;
          row_mask_d = row_mask;
          col_mask_d = col_mask;
          cnt_d      = '0;
          state_d    = (k_len == 8'd0) ? S_WRITE : S_FEED;
        end
      end
      S_FEED: begin
        a_addr_d = a_addr_q + AW'(stride_a_q);
        b_addr_d = b_addr_q + AW'(stride_b_q);
        if (last_feed) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (last_drain) begin
          state_d = S_WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
        c_addr_d = c_addr_q + AW'(stride_c_q);
        if (last_write) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Completion has priority over a simultaneous clear.
    if (clear_done || accept) done_d = 1'b0;
    if ((state_q == S_WRITE) && last_write) done_d = 1'b1;
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      k_len_q    <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      c_addr_q   <= '0;
      stride_a_q <= '0;
      stride_b_q <= '0;
      stride_c_q <= '0;
      row_mask_q <= '0;
      col_mask_q <= '0;
      feed_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_len_q    <= k_len_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      c_addr_q   <= c_addr_d;
      stride_a_q <= stride_a_d;
      stride_b_q <= stride_b_d;
      stride_c_q <= stride_c_d;
      row_mask_q <= row_mask_d;
      col_mask_q <= col_mask_d;
      feed_vld_q <= feed_vld_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign a_rd_addr = (state_q == S_FEED) ? a_addr_q : '0;
  assign b_rd_addr = (state_q == S_FEED) ? b_addr_q : '0;

  // Lane gating: only data returned for a FEED address enters the array.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_lane[i] = (feed_vld_q && row_mask_q[i]) ? a_rd_data[i*DW +: DW] : '0;
      b_lane[i] = (feed_vld_q && col_mask_q[i]) ? b_rd_data[i*DW +: DW] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_skew[i] = a_lane[i];
      assign b_skew[i] = b_lane[i];
    end else begin : g_delay
      logic [DW-1:0] a_sr_q [i];
      logic [DW-1:0] a_sr_d [i];
      logic [DW-1:0] b_sr_q [i];
      logic [DW-1:0] b_sr_d [i];
      // Lane i is delayed i cycles so operands meet on the anti-diagonal.
      always_comb begin
        a_sr_d[0] = a_lane[i];
        b_sr_d[0] = b_lane[i];
        for (int s = 1; s < i; s++) begin
          a_sr_d[s] = a_sr_q[s-1];
          b_sr_d[s] = b_sr_q[s-1];
        end
      end
      // Skew shift-register storage.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int s = 0; s < i; s++) begin
            a_sr_q[s] <= '0;
            b_sr_q[s] <= '0;
          end
        end else begin
          for (int s = 0; s < i; s++) begin
            a_sr_q[s] <= a_sr_d[s];
            b_sr_q[s] <= b_sr_d[s];
          end
        end
      end
      assign a_skew[i] = a_sr_q[i-1];
      assign b_skew[i] = b_sr_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0]   a_in, b_in, pe_a_q, pe_a_d, pe_b_q, pe_b_d;
      logic [OW-1:0]   acc_q, acc_d;
      logic [2*DW-1:0] prod;

      if (j == 0) begin : g_a_edge
        assign a_in = a_skew[i];
      end else begin : g_a_int
        assign a_in = a_out[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = b_skew[j];
      end else begin : g_b_int
        assign b_in = b_out[i-1][j];
      end

      assign prod = (2*DW)'(a_in) * (2*DW)'(b_in);

      // PE: forward operands, clear on a fresh start, accumulate while busy.
      always_comb begin
        pe_a_d = a_in;
        pe_b_d = b_in;
        acc_d  = acc_q;
        if (accept && !accumulate) begin
          acc_d = '0;
        end else if (state_q != S_IDLE) begin
          acc_d = acc_q + OW'(prod);
        end
      end

      // PE operand and accumulator registers.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pe_a_q <= '0;
          pe_b_q <= '0;
          acc_q  <= '0;
        end else begin
          pe_a_q <= pe_a_d;
          pe_b_q <= pe_b_d;
          acc_q  <= acc_d;
        end
      end

      assign a_out[i][j] = pe_a_q;
      assign b_out[i][j] = pe_b_q;
      assign acc_w[i][j] = acc_q;
    end
  end

  // Result write port: row cnt_q of the accumulators during WRITE.
  always_comb begin
    c_wr_en   = 1'b0;
    c_wr_addr = '0;
    c_wr_data = '0;
    if (state_q == S_WRITE) begin
      c_wr_addr = c_addr_q;
      for (int r = 0; r < N; r++) begin
        if (cnt_q == CW'(r)) begin
          c_wr_en = row_mask_q[r];
          for (int j = 0; j < N; j++) begin
            c_wr_data[j*OW +: OW] = acc_w[r][j];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
